// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: opcode constants, ALU operation encoding,
// immediate format selection and small decode helpers.
package rv32i_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    function automatic imm_fmt_e imm_fmt_of(input logic [6:0] opcode);
        imm_fmt_e fmt;
        case (opcode)
            OP_LUI, OP_AUIPC:                      fmt = IMM_U;
            OP_JAL:                                fmt = IMM_J;
            OP_JALR, OP_LOAD, OP_IMM,
            OP_FENCE, OP_SYSTEM:                   fmt = IMM_I;
            OP_BRANCH:                             fmt = IMM_B;
            OP_STORE:                              fmt = IMM_S;
            default:                               fmt = IMM_NONE;
        endcase
        return fmt;
    endfunction

    // funct7[5] selects SUB only for register-register ops; for shifts it
    // selects the arithmetic variant in both OP and OP-IMM.
    function automatic alu_op_e alu_op_of(input logic [2:0] funct3,
                                          input logic       alt,
                                          input logic       is_reg);
        alu_op_e op;
        case (funct3)
            3'b000:  op = (is_reg && alt) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: decodes the immediate format from the opcode and
// produces the sign-extended 32-bit immediate.
//   instr  in   32  instruction word
//   imm    out  32  sign-extended immediate (0 for formats without one)
module imm_gen
    import rv32i_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm
);

    always_comb begin
        imm = '0;
        case (imm_fmt_of(instr[6:0]))
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7],
                            instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12],
                            instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I instruction decode stage with operand forwarding, load-use hazard
// detection and the ID/EX pipeline register (valid/ready handshake).
//   pll_1_200MHz, reset           clock, synchronous active-high reset
//   if_valid/if_instr/if_pc       instruction from the IF/ID latch
//   id_ready                      stage accepts the IF instruction
//   flush                         redirect from EX, kills ID and ID/EX
//   ex_ready                      EX accepts the ID/EX contents
//   rf_read_reg1/2, rf_read_data1/2  register file read ports
//   ex_/mem_/wb_*                 downstream destinations and results
//   id_ex_*                       ID/EX pipeline register outputs
module decode_stage
    import rv32i_pkg::*;
#(
    parameter int unsigned      XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = 32'h0000_0000
) (
    input  logic            pll_1_200MHz,
    input  logic            reset,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic            id_ready,
    input  logic            flush,
    input  logic            ex_ready,
    output logic [4:0]      rf_read_reg1,
    output logic [4:0]      rf_read_reg2,
    input  logic [XLEN-1:0] rf_read_data1,
    input  logic [XLEN-1:0] rf_read_data2,
    input  logic [4:0]      ex_rd,
    input  logic [4:0]      mem_rd,
    input  logic [4:0]      wb_rd,
    input  logic            ex_reg_write,
    input  logic            mem_reg_write,
    input  logic            wb_reg_write,
    input  logic            ex_mem_read,
    input  logic [XLEN-1:0] ex_result,
    input  logic [XLEN-1:0] mem_result,
    input  logic [XLEN-1:0] wb_data,
    output logic            id_ex_valid,
    output logic [XLEN-1:0] id_ex_pc,
    output logic [XLEN-1:0] id_ex_rs1_data,
    output logic [XLEN-1:0] id_ex_rs2_data,
    output logic [XLEN-1:0] id_ex_imm,
    output logic [4:0]      id_ex_rd,
    output logic [2:0]      id_ex_funct3,
    output logic [3:0]      id_ex_alu_op,
    output logic            id_ex_alu_src_imm,
    output logic            id_ex_alu_src_pc,
    output logic            id_ex_reg_write,
    output logic            id_ex_mem_read,
    output logic            id_ex_mem_write,
    output logic            id_ex_branch,
    output logic            id_ex_jump,
    output logic            id_ex_illegal
);

    logic [6:0]      opcode;
    logic [4:0]      rs1, rs2, rd;
    logic [2:0]      funct3;
    logic [31:0]     imm;
    logic [XLEN-1:0] rs1_val, rs2_val;

    alu_op_e alu_op;
    logic    src_imm, src_pc;
    logic    dec_reg_write, dec_mem_read, dec_mem_write;
    logic    dec_branch, dec_jump, dec_illegal;
    logic    rs1_used, rs2_used;
    logic    load_use;
    logic    advance;

    assign opcode = if_instr[6:0];
    assign rd     = if_instr[11:7];
    assign funct3 = if_instr[14:12];
    assign rs1    = if_instr[19:15];
    assign rs2    = if_instr[24:20];

    assign rf_read_reg1 = rs1;
    assign rf_read_reg2 = rs2;

    imm_gen u_imm_gen (
        .instr (if_instr),
        .imm   (imm)
    );

    always_comb begin
        alu_op        = ALU_ADD;
        src_imm       = 1'b0;
        src_pc        = 1'b0;
        dec_reg_write = 1'b0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_branch    = 1'b0;
        dec_jump      = 1'b0;
        dec_illegal   = 1'b0;
        rs1_used      = 1'b1;
        rs2_used      = 1'b0;
        case (opcode)
            OP_LUI: begin
                alu_op        = ALU_PASS_B;
                src_imm       = 1'b1;
                dec_reg_write = 1'b1;
                rs1_used      = 1'b0;
            end
            OP_AUIPC: begin
                src_imm       = 1'b1;
                src_pc        = 1'b1;
                dec_reg_write = 1'b1;
                rs1_used      = 1'b0;
            end
            OP_JAL: begin
                src_pc        = 1'b1;
                dec_jump      = 1'b1;
                dec_reg_write = 1'b1;
                rs1_used      = 1'b0;
            end
            OP_JALR: begin
                src_pc        = 1'b1;
                dec_jump      = 1'b1;
                dec_reg_write = 1'b1;
            end
            OP_BRANCH: begin
                alu_op     = ALU_SUB;
                dec_branch = 1'b1;
                rs2_used   = 1'b1;
            end
            OP_LOAD: begin
                src_imm       = 1'b1;
                dec_mem_read  = 1'b1;
                dec_reg_write = 1'b1;
            end
            OP_STORE: begin
                src_imm       = 1'b1;
                dec_mem_write = 1'b1;
                rs2_used      = 1'b1;
            end
            OP_IMM: begin
                alu_op        = alu_op_of(funct3, if_instr[30], 1'b0);
                src_imm       = 1'b1;
                dec_reg_write = 1'b1;
            end
            OP_REG: begin
                alu_op        = alu_op_of(funct3, if_instr[30], 1'b1);
                dec_reg_write = 1'b1;
                rs2_used      = 1'b1;
            end
            OP_FENCE, OP_SYSTEM: begin
                // Treated as NOP: issues as a valid instruction with no effects.
            end
            default: dec_illegal = 1'b1;
        endcase
        if (rd == 5'd0)
            dec_reg_write = 1'b0;
    end

    // Youngest producer wins. A load in EX has no data yet, so it is skipped
    // here and covered by the load-use stall instead. WB must be bypassed
    // because the register file only commits on the clock edge.
    function automatic logic [XLEN-1:0] fwd(input logic [4:0]      rs,
                                            input logic [XLEN-1:0] rf_val);
        if (rs == 5'd0)
            return '0;
        else if (ex_reg_write && ex_rd == rs && !ex_mem_read)
            return ex_result;
        else if (mem_reg_write && mem_rd == rs)
            return mem_result;
        else if (wb_reg_write && wb_rd == rs)
            return wb_data;
        else
            return rf_val;
    endfunction

    always_comb begin
        rs1_val = fwd(rs1, rf_read_data1);
        rs2_val = fwd(rs2, rf_read_data2);
    end

    assign load_use = if_valid && ex_mem_read && ex_reg_write && (ex_rd != 5'd0)
                   && ((rs1_used && ex_rd == rs1) || (rs2_used && ex_rd == rs2));

    assign advance  = ex_ready || !id_ex_valid;
    assign id_ready = (!load_use && advance) || flush;

    always_ff @(posedge pll_1_200MHz) begin
        if (reset) begin
            id_ex_valid       <= 1'b0;
            id_ex_pc          <= RESET_PC;
            id_ex_rs1_data    <= '0;
            id_ex_rs2_data    <= '0;
            id_ex_imm         <= '0;
            id_ex_rd          <= '0;
            id_ex_funct3      <= '0;
            id_ex_alu_op      <= '0;
            id_ex_alu_src_imm <= 1'b0;
            id_ex_alu_src_pc  <= 1'b0;
            id_ex_reg_write   <= 1'b0;
            id_ex_mem_read    <= 1'b0;
            id_ex_mem_write   <= 1'b0;
            id_ex_branch      <= 1'b0;
            id_ex_jump        <= 1'b0;
            id_ex_illegal     <= 1'b0;
        end else if (flush) begin
            id_ex_valid <= 1'b0;
        end else if (advance) begin
            if (load_use) begin
                id_ex_valid <= 1'b0;
            end else begin
                id_ex_valid       <= if_valid;
                id_ex_pc          <= if_pc;
                id_ex_rs1_data    <= rs1_val;
                id_ex_rs2_data    <= rs2_val;
                id_ex_imm         <= imm;
                id_ex_rd          <= rd;
                id_ex_funct3      <= funct3;
                id_ex_alu_op      <= alu_op;
                id_ex_alu_src_imm <= src_imm;
                id_ex_alu_src_pc  <= src_pc;
                id_ex_reg_write   <= dec_reg_write;
                id_ex_mem_read    <= dec_mem_read;
                id_ex_mem_write   <= dec_mem_write;
                id_ex_branch      <= dec_branch;
                id_ex_jump        <= dec_jump;
                id_ex_illegal     <= dec_illegal;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage.
module tb_decode_stage;
    import rv32i_pkg::*;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_instr, if_pc;
    logic        id_ready, flush, ex_ready;
    logic [4:0]  rf_read_reg1, rf_read_reg2;
    logic [31:0] rf_read_data1, rf_read_data2;
    logic [4:0]  ex_rd, mem_rd, wb_rd;
    logic        ex_reg_write, mem_reg_write, wb_reg_write, ex_mem_read;
    logic [31:0] ex_result, mem_result, wb_data;
    logic        id_ex_valid;
    logic [31:0] id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm;
    logic [4:0]  id_ex_rd;
    logic [2:0]  id_ex_funct3;
    logic [3:0]  id_ex_alu_op;
    logic        id_ex_alu_src_imm, id_ex_alu_src_pc;
    logic        id_ex_reg_write, id_ex_mem_read, id_ex_mem_write;
    logic        id_ex_branch, id_ex_jump, id_ex_illegal;
    logic [7:0]  ctrl;

    // {reg_write, mem_read, mem_write, branch, jump, illegal, src_imm, src_pc}
    assign ctrl = {id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_branch,
                   id_ex_jump, id_ex_illegal, id_ex_alu_src_imm, id_ex_alu_src_pc};

    decode_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .pll_1_200MHz      (clk),
        .reset             (reset),
        .if_valid          (if_valid),
        .if_instr          (if_instr),
        .if_pc             (if_pc),
        .id_ready          (id_ready),
        .flush             (flush),
        .ex_ready          (ex_ready),
        .rf_read_reg1      (rf_read_reg1),
        .rf_read_reg2      (rf_read_reg2),
        .rf_read_data1     (rf_read_data1),
        .rf_read_data2     (rf_read_data2),
        .ex_rd             (ex_rd),
        .mem_rd            (mem_rd),
        .wb_rd             (wb_rd),
        .ex_reg_write      (ex_reg_write),
        .mem_reg_write     (mem_reg_write),
        .wb_reg_write      (wb_reg_write),
        .ex_mem_read       (ex_mem_read),
        .ex_result         (ex_result),
        .mem_result        (mem_result),
        .wb_data           (wb_data),
        .id_ex_valid       (id_ex_valid),
        .id_ex_pc          (id_ex_pc),
        .id_ex_rs1_data    (id_ex_rs1_data),
        .id_ex_rs2_data    (id_ex_rs2_data),
        .id_ex_imm         (id_ex_imm),
        .id_ex_rd          (id_ex_rd),
        .id_ex_funct3      (id_ex_funct3),
        .id_ex_alu_op      (id_ex_alu_op),
        .id_ex_alu_src_imm (id_ex_alu_src_imm),
        .id_ex_alu_src_pc  (id_ex_alu_src_pc),
        .id_ex_reg_write   (id_ex_reg_write),
        .id_ex_mem_read    (id_ex_mem_read),
        .id_ex_mem_write   (id_ex_mem_write),
        .id_ex_branch      (id_ex_branch),
        .id_ex_jump        (id_ex_jump),
        .id_ex_illegal     (id_ex_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_fwd();
        ex_reg_write  = 1'b0;
        mem_reg_write = 1'b0;
        wb_reg_write  = 1'b0;
        ex_mem_read   = 1'b0;
        ex_rd         = 5'd0;
        mem_rd        = 5'd0;
        wb_rd         = 5'd0;
    endtask

    // Decode table: instruction, expected immediate, ALU op, control bits.
    logic [31:0] t_instr [0:10];
    logic [31:0] t_imm   [0:10];
    alu_op_e     t_alu   [0:10];
    logic [7:0]  t_ctrl  [0:10];

    initial begin
        t_instr = '{32'h402081B3, 32'h4030D293, 32'h0020A423, 32'hFE208EE3,
                    32'h001000EF, 32'h004100E7, 32'h00001097, 32'hFF80A283,
                    32'h00000073, 32'h40000093, 32'hFFFFFFFF};
        t_imm   = '{32'h0,        32'h403,      32'h8,        32'hFFFFFFFC,
                    32'h800,      32'h4,        32'h1000,     32'hFFFFFFF8,
                    32'h0,        32'h400,      32'h0};
        t_alu   = '{ALU_SUB, ALU_SRA, ALU_ADD, ALU_SUB, ALU_ADD, ALU_ADD,
                    ALU_ADD, ALU_ADD, ALU_ADD, ALU_ADD, ALU_ADD};
        t_ctrl  = '{8'b1000_0000, 8'b1000_0010, 8'b0010_0010, 8'b0001_0000,
                    8'b1000_1001, 8'b1000_1001, 8'b1000_0011, 8'b1100_0010,
                    8'b0000_0000, 8'b1000_0010, 8'b0000_0100};

        reset = 1'b1; flush = 1'b0; ex_ready = 1'b1;
        if_valid = 1'b0; if_instr = 32'h0; if_pc = 32'h0;
        rf_read_data1 = 32'h0; rf_read_data2 = 32'h0;
        ex_result = 32'h0; mem_result = 32'h0; wb_data = 32'h0;
        clear_fwd();
        tick();
        tick();
        chk("reset_valid", 32'(id_ex_valid), 32'd0);
        chk("reset_pc",    id_ex_pc,         RST_PC);
        chk("reset_ctrl",  32'(ctrl),        32'd0);
        reset = 1'b0;

        // ADDI x5,x0,-1
        if_valid = 1'b1; if_instr = 32'hFFF00293; if_pc = 32'h100;
        rf_read_data1 = 32'h55; rf_read_data2 = 32'h66;
        #1;
        chk("addi_rf1", 32'(rf_read_reg1), 32'd0);
        chk("addi_rf2", 32'(rf_read_reg2), 32'd31);
        chk("addi_ready", 32'(id_ready), 32'd1);
        tick();
        chk("addi_valid", 32'(id_ex_valid), 32'd1);
        chk("addi_pc",    id_ex_pc,         32'h100);
        chk("addi_imm",   id_ex_imm,        32'hFFFF_FFFF);
        chk("addi_rd",    32'(id_ex_rd),    32'd5);
        chk("addi_alu",   32'(id_ex_alu_op), 32'(ALU_ADD));
        chk("addi_srcimm", 32'(id_ex_alu_src_imm), 32'd1);
        chk("addi_rs1",   id_ex_rs1_data,   32'd0);

        // ADD x3,x1,x2: EX beats MEM
        if_instr = 32'h002081B3; if_pc = 32'h104;
        rf_read_data1 = 32'd10; rf_read_data2 = 32'd20;
        ex_reg_write = 1'b1; ex_rd = 5'd1; ex_result = 32'd7;
        mem_reg_write = 1'b1; mem_rd = 5'd1; mem_result = 32'd9;
        tick();
        chk("fwd_ex_rs1", id_ex_rs1_data, 32'd7);
        chk("fwd_ex_rs2", id_ex_rs2_data, 32'd20);
        chk("add_ctrl",   32'(ctrl),      32'h80);

        // WB-only bypass on rs2
        clear_fwd();
        wb_reg_write = 1'b1; wb_rd = 5'd2; wb_data = 32'd55;
        tick();
        chk("fwd_wb_rs1", id_ex_rs1_data, 32'd10);
        chk("fwd_wb_rs2", id_ex_rs2_data, 32'd55);

        // MEM beats WB
        clear_fwd();
        mem_reg_write = 1'b1; mem_rd = 5'd1; mem_result = 32'd9;
        wb_reg_write = 1'b1; wb_rd = 5'd1; wb_data = 32'd3;
        tick();
        chk("fwd_mem_rs1", id_ex_rs1_data, 32'd9);
        chk("fwd_mem_rs2", id_ex_rs2_data, 32'd20);

        // Load-use: LW x4 in EX, ADD x6,x4,x1 in ID
        clear_fwd();
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd4; ex_result = 32'hBAD;
        if_instr = 32'h00120333; if_pc = 32'h200;
        rf_read_data1 = 32'hDEAD; rf_read_data2 = 32'h11;
        #1;
        chk("lu_ready", 32'(id_ready), 32'd0);
        tick();
        chk("lu_bubble", 32'(id_ex_valid), 32'd0);
        clear_fwd();
        mem_reg_write = 1'b1; mem_rd = 5'd4; mem_result = 32'h1234;
        #1;
        chk("lu_release_ready", 32'(id_ready), 32'd1);
        tick();
        chk("lu_issue_valid", 32'(id_ex_valid), 32'd1);
        chk("lu_issue_pc",    id_ex_pc,         32'h200);
        chk("lu_issue_rs1",   id_ex_rs1_data,   32'h1234);
        chk("lu_issue_rs2",   id_ex_rs2_data,   32'h11);
        chk("lu_issue_rd",    32'(id_ex_rd),    32'd6);

        // LUI x4 with a load in EX: rs fields are not used, no stall
        clear_fwd();
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd4;
        if_instr = 32'h12345237; if_pc = 32'h204;
        #1;
        chk("lui_ready_rd4", 32'(id_ready), 32'd1);
        ex_rd = 5'd8;   // matches the LUI's rs1 bit field
        #1;
        chk("lui_ready_rd8", 32'(id_ready), 32'd1);
        tick();
        chk("lui_valid", 32'(id_ex_valid), 32'd1);
        chk("lui_imm",   id_ex_imm,        32'h1234_5000);
        chk("lui_alu",   32'(id_ex_alu_op), 32'(ALU_PASS_B));
        chk("lui_rd",    32'(id_ex_rd),    32'd4);

        // ADD x0,x0,x0 with a load to x0 in EX
        ex_rd = 5'd0; ex_result = 32'hBAD;
        if_instr = 32'h00000033; if_pc = 32'h208;
        rf_read_data1 = 32'h99; rf_read_data2 = 32'h98;
        #1;
        chk("x0_ready", 32'(id_ready), 32'd1);
        ex_mem_read = 1'b0;
        tick();
        chk("x0_valid", 32'(id_ex_valid), 32'd1);
        chk("x0_rs1",   id_ex_rs1_data,   32'd0);
        chk("x0_rs2",   id_ex_rs2_data,   32'd0);
        chk("x0_rw",    32'(id_ex_reg_write), 32'd0);

        // Decode table
        clear_fwd();
        rf_read_data1 = 32'h0; rf_read_data2 = 32'h0;
        for (int i = 0; i < 11; i++) begin
            if_instr = t_instr[i];
            if_pc    = 32'h300 + 32'(i * 4);
            tick();
            chk($sformatf("tbl%0d_valid", i), 32'(id_ex_valid), 32'd1);
            chk($sformatf("tbl%0d_imm", i),   id_ex_imm,        t_imm[i]);
            chk($sformatf("tbl%0d_alu", i),   32'(id_ex_alu_op), 32'(t_alu[i]));
            chk($sformatf("tbl%0d_ctrl", i),  32'(ctrl),        32'(t_ctrl[i]));
        end

        // EX back-pressure: ID/EX holds the illegal instruction
        ex_ready = 1'b0;
        if_instr = 32'hFFF00293; if_pc = 32'h400;
        #1;
        chk("stall_ready", 32'(id_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("stall%0d_valid", i), 32'(id_ex_valid), 32'd1);
            chk($sformatf("stall%0d_pc", i),    id_ex_pc,         32'h328);
            chk($sformatf("stall%0d_ctrl", i),  32'(ctrl),        32'h04);
            chk($sformatf("stall%0d_ready", i), 32'(id_ready),    32'd0);
        end
        flush = 1'b1;
        #1;
        chk("flush_ready", 32'(id_ready), 32'd1);
        tick();
        chk("flush_valid", 32'(id_ex_valid), 32'd0);
        flush = 1'b0;
        ex_ready = 1'b1;
        tick();
        chk("post_flush_valid", 32'(id_ex_valid), 32'd1);
        chk("post_flush_pc",    id_ex_pc,         32'h400);
        chk("post_flush_imm",   id_ex_imm,        32'hFFFF_FFFF);

        // if_valid low: register loads but not live
        if_valid = 1'b0;
        tick();
        chk("ifv0_valid", 32'(id_ex_valid), 32'd0);
        if_valid = 1'b1;

        // Reset during a load-use stall
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd4;
        if_instr = 32'h00120333; if_pc = 32'h500;
        #1;
        chk("rst_lu_ready", 32'(id_ready), 32'd0);
        reset = 1'b1;
        tick();
        chk("rst2_valid", 32'(id_ex_valid), 32'd0);
        chk("rst2_pc",    id_ex_pc,         RST_PC);
        chk("rst2_ctrl",  32'(ctrl),        32'd0);
        chk("rst2_imm",   id_ex_imm,        32'd0);
        chk("rst2_rd",    32'(id_ex_rd),    32'd0);
        reset = 1'b0;
        clear_fwd();
        tick();
        chk("after_rst_valid", 32'(id_ex_valid), 32'd1);
        chk("after_rst_pc",    id_ex_pc,         32'h500);
        chk("after_rst_rd",    32'(id_ex_rd),    32'd6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
